ddr4_app_responder: RTL and testbench

DDR4_APP_RESPONDER -- requirements
Module: ddr4_app_responder

---
 rtl/ddr4_app_responder_pkg.sv | 30 +++
 rtl/app_wdf_fifo.sv | 59 +++++
 rtl/ddr4_app_responder.sv | 162 ++++++++++++++++
 tb/tb_ddr4_app_responder.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_app_responder_pkg.sv
// Shared command encodings, bus widths and byte-merge helper for the DDR4 app responder.
package ddr4_app_responder_pkg;

    localparam logic [2:0] CMD_WRITE  = 3'b000;
    localparam logic [2:0] CMD_READ   = 3'b001;
    localparam int         APP_ADDR_W = 28;
    localparam int         APP_DATA_W = 512;
    localparam int         APP_MASK_W = 64;

    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

    // Mask bit set means the byte keeps its old value.
    function automatic logic [APP_DATA_W-1:0] apply_mask(
        input logic [APP_DATA_W-1:0] old_word,
        input logic [APP_DATA_W-1:0] new_word,
        input logic [APP_MASK_W-1:0] mask
    );
        logic [APP_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < APP_MASK_W; i++) begin
            if (!mask[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/app_wdf_fifo.sv
// Two-entry write-data FIFO holding data and byte mask per beat.
module app_wdf_fifo
    import ddr4_app_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [APP_DATA_W-1:0] push_data,
    input  logic [APP_MASK_W-1:0] push_mask,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [APP_DATA_W-1:0] head_data,
    output logic [APP_MASK_W-1:0] head_mask
);

    logic [APP_DATA_W-1:0] data_q [2];
    logic [APP_MASK_W-1:0] mask_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = data_q[rd_ptr_q];
    assign head_mask = mask_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_q[wr_ptr_q] <= push_data;
            mask_q[wr_ptr_q] <= push_mask;
        end
    end

endmodule

// File: rtl/ddr4_app_responder.sv
// Behavioural DDR4 MIG app-interface responder: calibration delay, small backing store,
// single pending write command, 2-deep write-data FIFO and fixed-latency read pipeline.
module ddr4_app_responder
    import ddr4_app_responder_pkg::*;
#(
    parameter int CAL_CYCLES  = 64,
    parameter int MEM_AW      = 4,
    parameter int RD_LATENCY  = 4,
    parameter int BUSY_PERIOD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_calib_complete,
    input  logic                  ddr4_app_en,
    input  logic [2:0]            ddr4_app_cmd,
    input  logic [APP_ADDR_W-1:0] ddr4_app_addr,
    output logic                  ddr4_app_rdy,
    input  logic                  ddr4_app_wdf_wren,
    input  logic                  ddr4_app_wdf_end,
    input  logic [APP_DATA_W-1:0] ddr4_app_wdf_data,
    input  logic [APP_MASK_W-1:0] ddr4_app_wdf_mask,
    output logic                  ddr4_app_wdf_rdy,
    output logic [APP_DATA_W-1:0] ddr4_app_rd_data,
    output logic                  ddr4_app_rd_data_valid,
    output logic                  ddr4_app_rd_data_end,
    output logic                  err_proto
);

    localparam int MemDepth = 2 ** MEM_AW;
    localparam int CalW     = $clog2(CAL_CYCLES + 1) + 1;
    localparam int BusyW    = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;

    logic [CalW-1:0]       cal_cnt_q;
    logic                  calib_q;
    logic [BusyW-1:0]      busy_cnt_q;
    logic                  busy_slot;
    logic                  wcmd_pending_q;
    logic [MEM_AW-1:0]     wcmd_idx_q;
    logic                  err_q;
    logic [RD_LATENCY-1:0] rd_valid_q;
    logic [APP_DATA_W-1:0] rd_data_q [RD_LATENCY];
    logic [APP_DATA_W-1:0] mem [MemDepth];

    logic                  cmd_legal;
    logic                  cmd_accept;
    logic                  wr_cmd_accept;
    logic                  rd_accept;
    logic                  beat_accept;
    logic                  proto_err;
    logic                  commit;
    logic [MEM_AW-1:0]     cmd_idx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [APP_DATA_W-1:0] fifo_data;
    logic [APP_MASK_W-1:0] fifo_mask;
    logic                  unused_addr;

    // Column address selects 8 columns per 512-bit word; upper bits alias.
    assign cmd_idx     = ddr4_app_addr[MEM_AW+2:3];
    assign unused_addr = ^{ddr4_app_addr[APP_ADDR_W-1:MEM_AW+3], ddr4_app_addr[2:0]};

    assign busy_slot = (BUSY_PERIOD > 0) && calib_q &&
                       (32'(busy_cnt_q) == 32'(BUSY_PERIOD - 1));

    assign init_calib_complete = calib_q;
    assign ddr4_app_rdy        = calib_q & ~wcmd_pending_q & ~busy_slot;
    assign ddr4_app_wdf_rdy    = calib_q & ~fifo_full;

    assign cmd_legal     = cmd_is_legal(ddr4_app_cmd);
    assign cmd_accept    = ddr4_app_en & ddr4_app_rdy & cmd_legal;
    assign wr_cmd_accept = cmd_accept & (ddr4_app_cmd == CMD_WRITE);
    assign rd_accept     = cmd_accept & (ddr4_app_cmd == CMD_READ);
    assign beat_accept   = ddr4_app_wdf_wren & ddr4_app_wdf_rdy & ddr4_app_wdf_end;
    assign commit        = wcmd_pending_q & ~fifo_empty;

    assign proto_err = (ddr4_app_en & ~cmd_legal) |
                       (ddr4_app_wdf_wren & ~ddr4_app_wdf_end) |
                       (ddr4_app_wdf_wren & ~ddr4_app_wdf_rdy) |
                       (ddr4_app_en & ~calib_q);

    assign err_proto              = err_q;
    assign ddr4_app_rd_data       = rd_data_q[RD_LATENCY-1];
    assign ddr4_app_rd_data_valid = rd_valid_q[RD_LATENCY-1];
    assign ddr4_app_rd_data_end   = rd_valid_q[RD_LATENCY-1];

    app_wdf_fifo u_wdf_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (beat_accept),
        .push_data (ddr4_app_wdf_data),
        .push_mask (ddr4_app_wdf_mask),
        .pop       (commit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_data),
        .head_mask (fifo_mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
        end else if (!calib_q) begin
            cal_cnt_q <= cal_cnt_q + 1'b1;
            if (32'(cal_cnt_q) + 32'd1 >= 32'(CAL_CYCLES)) begin
                calib_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt_q <= '0;
        end else if ((BUSY_PERIOD > 0) && calib_q) begin
            busy_cnt_q <= busy_slot ? '0 : busy_cnt_q + 1'b1;
        end
    end

    // Commit and a new write accept never coincide: rdy is low while pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcmd_pending_q <= 1'b0;
            wcmd_idx_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            if (commit) begin
                wcmd_pending_q <= 1'b0;
            end else if (wr_cmd_accept) begin
                wcmd_pending_q <= 1'b1;
                wcmd_idx_q     <= cmd_idx;
            end
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= '0;
        end else begin
            rd_valid_q[0] <= rd_accept;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_valid_q[i] <= rd_valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q[0] <= mem[cmd_idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_data_q[i] <= rd_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wcmd_idx_q] <= apply_mask(mem[wcmd_idx_q], fifo_data, fifo_mask);
        end
    end

endmodule

// File: tb/tb_ddr4_app_responder.sv
// Self-checking bench for ddr4_app_responder against a word-array memory model.
module tb_ddr4_app_responder;

    localparam int LAT   = 4;
    localparam int CAL   = 64;
    localparam int DEPTH = 16;

    logic         clk;
    logic         reset;
    logic         init_calib_complete;
    logic         ddr4_app_en;
    logic [2:0]   ddr4_app_cmd;
    logic [27:0]  ddr4_app_addr;
    logic         ddr4_app_rdy;
    logic         ddr4_app_wdf_wren;
    logic         ddr4_app_wdf_end;
    logic [511:0] ddr4_app_wdf_data;
    logic [63:0]  ddr4_app_wdf_mask;
    logic         ddr4_app_wdf_rdy;
    logic [511:0] ddr4_app_rd_data;
    logic         ddr4_app_rd_data_valid;
    logic         ddr4_app_rd_data_end;
    logic         err_proto;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [511:0] rd_q[$];
    int           rd_cyc_q[$];
    bit           rd_end_q[$];

    logic [511:0] model_mem [DEPTH];
    bit           model_known [DEPTH];

    ddr4_app_responder #(
        .CAL_CYCLES  (CAL),
        .MEM_AW      (4),
        .RD_LATENCY  (LAT),
        .BUSY_PERIOD (0)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .init_calib_complete    (init_calib_complete),
        .ddr4_app_en            (ddr4_app_en),
        .ddr4_app_cmd           (ddr4_app_cmd),
        .ddr4_app_addr          (ddr4_app_addr),
        .ddr4_app_rdy           (ddr4_app_rdy),
        .ddr4_app_wdf_wren      (ddr4_app_wdf_wren),
        .ddr4_app_wdf_end       (ddr4_app_wdf_end),
        .ddr4_app_wdf_data      (ddr4_app_wdf_data),
        .ddr4_app_wdf_mask      (ddr4_app_wdf_mask),
        .ddr4_app_wdf_rdy       (ddr4_app_wdf_rdy),
        .ddr4_app_rd_data       (ddr4_app_rd_data),
        .ddr4_app_rd_data_valid (ddr4_app_rd_data_valid),
        .ddr4_app_rd_data_end   (ddr4_app_rd_data_end),
        .err_proto              (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ddr4_app_rd_data_valid === 1'b1) begin
            rd_q.push_back(ddr4_app_rd_data);
            rd_cyc_q.push_back(cyc);
            rd_end_q.push_back(ddr4_app_rd_data_end);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int widx(input logic [27:0] a);
        return int'(a >> 3) % DEPTH;
    endfunction

    function automatic logic [511:0] merge(input logic [511:0] old_w, input logic [511:0] new_w,
                                           input logic [63:0] mask);
        logic [511:0] keep;
        for (int b = 0; b < 512; b++) keep[b] = mask[b/8];
        return (old_w & keep) | (new_w & ~keep);
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        ddr4_app_en       = 1'b0;
        ddr4_app_cmd      = 3'b000;
        ddr4_app_addr     = '0;
        ddr4_app_wdf_wren = 1'b0;
        ddr4_app_wdf_end  = 1'b0;
        ddr4_app_wdf_data = '0;
        ddr4_app_wdf_mask = '0;
    endtask

    task automatic wait_calib(output int n);
        n = 0;
        while (init_calib_complete !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr, output int acc);
        int t = 0;
        while (ddr4_app_rdy !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL cmd_wait: rdy=%b after %0d cycles, required 1", ddr4_app_rdy, t);
        end
        ddr4_app_en   = 1'b1;
        ddr4_app_cmd  = cmd;
        ddr4_app_addr = addr;
        acc = cyc;
        @(posedge clk); #1;
        ddr4_app_en = 1'b0;
    endtask

    task automatic send_write(input logic [27:0] addr, input logic [511:0] data,
                              input logic [63:0] mask);
        int t = 0;
        while (!(ddr4_app_rdy === 1'b1 && ddr4_app_wdf_rdy === 1'b1) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL write_wait: rdy=%b wdf_rdy=%b, required 1/1", ddr4_app_rdy,
                     ddr4_app_wdf_rdy);
        end
        ddr4_app_en       = 1'b1;
        ddr4_app_cmd      = 3'b000;
        ddr4_app_addr     = addr;
        ddr4_app_wdf_wren = 1'b1;
        ddr4_app_wdf_end  = 1'b1;
        ddr4_app_wdf_data = data;
        ddr4_app_wdf_mask = mask;
        @(posedge clk); #1;
        ddr4_app_en       = 1'b0;
        ddr4_app_wdf_wren = 1'b0;
        ddr4_app_wdf_end  = 1'b0;
        model_mem[widx(addr)]   = model_known[widx(addr)] ?
                                  merge(model_mem[widx(addr)], data, mask) : data;
        model_known[widx(addr)] = model_known[widx(addr)] || (mask == '0);
    endtask

    task automatic get_read(output logic [511:0] d, output int c, output bit e);
        int t = 0;
        while (rd_q.size() == 0 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL read_timeout: no read beat after %0d cycles, required one", t);
            d = 'x; c = -1; e = 1'b0;
        end else begin
            d = rd_q.pop_front();
            c = rd_cyc_q.pop_front();
            e = rd_end_q.pop_front();
        end
    endtask

    task automatic test_reset();
        int  n = 0;
        bit  early = 1'b0;
        reset = 1'b0;
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({init_calib_complete, ddr4_app_rdy, ddr4_app_wdf_rdy, ddr4_app_rd_data_valid,
             ddr4_app_rd_data_end, err_proto} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {init_calib_complete, ddr4_app_rdy, ddr4_app_wdf_rdy,
                      ddr4_app_rd_data_valid, ddr4_app_rd_data_end, err_proto});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        while (init_calib_complete !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
            if (init_calib_complete !== 1'b1 && (ddr4_app_rdy !== 1'b0 || ddr4_app_wdf_rdy !== 1'b0))
                early = 1'b1;
        end
        checks++;
        if (n !== CAL) begin
            errors++;
            $display("FAIL calib_cycles: got %0d, required %0d", n, CAL);
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_calib: got %b, required 0", early);
        end
        checks++;
        if ({ddr4_app_rdy, ddr4_app_wdf_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL rdy_at_calib: got %b, required 11", {ddr4_app_rdy, ddr4_app_wdf_rdy});
        end
    endtask

    task automatic test_write_read();
        logic [511:0] d;
        int           acc, c;
        bit           e;
        send_write(28'h08, {64{8'hA5}}, 64'h0);
        send_cmd(3'b001, 28'h08, acc);
        get_read(d, c, e);
        checks++;
        if (d !== {64{8'hA5}}) begin
            errors++;
            $display("FAIL wr_rd_data: got %h, required %h", d, {64{8'hA5}});
        end
        checks++;
        if (c !== acc + LAT || e !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_latency: got cycle %0d end %b, required %0d end 1", c, e,
                     acc + LAT);
        end
        repeat (6) @(posedge clk);
        #0;
        checks++;
        if (rd_q.size() !== 0) begin
            errors++;
            $display("FAIL wr_rd_single: got %0d extra beats, required 0", rd_q.size());
            rd_q.delete(); rd_cyc_q.delete(); rd_end_q.delete();
        end
    endtask

    task automatic test_mask();
        logic [511:0] d;
        logic [511:0] exp_d;
        int           acc, c;
        bit           e;
        exp_d = {{63{8'hFF}}, 8'h00};
        send_write(28'h10, {512{1'b1}}, 64'h0);
        send_write(28'h10, 512'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        send_cmd(3'b001, 28'h10, acc);
        get_read(d, c, e);
        checks++;
        if (d !== exp_d) begin
            errors++;
            $display("FAIL mask_merge: got %h, required %h", d, exp_d);
        end
    endtask

    task automatic test_early_data();
        logic [511:0] d1, d2, d;
        int           acc, c, t;
        bit           e;
        d1 = rand512();
        d2 = rand512();
        t = 0;
        while (ddr4_app_rdy !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        ddr4_app_wdf_wren = 1'b1;
        ddr4_app_wdf_end  = 1'b1;
        ddr4_app_wdf_mask = '0;
        ddr4_app_wdf_data = d1;
        @(posedge clk); #1;
        ddr4_app_wdf_data = d2;
        @(posedge clk); #1;
        ddr4_app_wdf_wren = 1'b0;
        ddr4_app_wdf_end  = 1'b0;
        checks++;
        if (ddr4_app_wdf_rdy !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: wdf_rdy=%b, required 0", ddr4_app_wdf_rdy);
        end
        ddr4_app_en   = 1'b1;
        ddr4_app_cmd  = 3'b000;
        ddr4_app_addr = 28'h28;
        @(posedge clk); #1;
        ddr4_app_en = 1'b0;
        checks++;
        if (ddr4_app_rdy !== 1'b0) begin
            errors++;
            $display("FAIL pending_rdy: rdy=%b after write cmd, required 0", ddr4_app_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if ({ddr4_app_rdy, ddr4_app_wdf_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL commit_next: rdy/wdf_rdy=%b, required 11",
                     {ddr4_app_rdy, ddr4_app_wdf_rdy});
        end
        model_mem[widx(28'h28)] = d1; model_known[widx(28'h28)] = 1'b1;
        send_cmd(3'b001, 28'h28, acc);
        get_read(d, c, e);
        checks++;
        if (d !== d1) begin
            errors++;
            $display("FAIL early_beat1: got %h, required %h", d, d1);
        end
        send_cmd(3'b000, 28'h30, acc);
        model_mem[widx(28'h30)] = d2; model_known[widx(28'h30)] = 1'b1;
        send_cmd(3'b001, 28'h30, acc);
        get_read(d, c, e);
        checks++;
        if (d !== d2) begin
            errors++;
            $display("FAIL early_beat2: got %h, required %h", d, d2);
        end
    endtask

    task automatic burst3(output int acc0);
        int t = 0;
        bit stall = 1'b0;
        while (ddr4_app_rdy !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        acc0 = cyc;
        for (int i = 0; i < 3; i++) begin
            if (ddr4_app_rdy !== 1'b1) stall = 1'b1;
            ddr4_app_en   = 1'b1;
            ddr4_app_cmd  = 3'b001;
            ddr4_app_addr = 28'(i * 8);
            @(posedge clk); #1;
        end
        ddr4_app_en = 1'b0;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL burst_rdy: rdy dropped during burst, required held");
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] d;
        int           acc0, c;
        bit           e;
        send_write(28'h00, rand512(), 64'h0);
        burst3(acc0);
        for (int i = 0; i < 3; i++) begin
            get_read(d, c, e);
            checks++;
            if (d !== model_mem[i] || c !== acc0 + i + LAT || e !== 1'b1) begin
                errors++;
                $display("FAIL b2b_read%0d: got %h @%0d end %b, required %h @%0d end 1", i, d,
                         c, e, model_mem[i], acc0 + i + LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [511:0] d, wd;
        logic [63:0]  m;
        logic [27:0]  a;
        int           acc, c, bad;
        bit           e;
        for (int i = 0; i < DEPTH; i++) begin
            a = 28'($urandom);
            a[6:3] = 4'(i);
            send_write(a, rand512(), 64'h0);
        end
        bad = 0;
        for (int n = 0; n < 60; n++) begin
            a = 28'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wd = rand512();
                m = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
                send_write(a, wd, m);
            end else begin
                send_cmd(3'b001, a, acc);
                get_read(d, c, e);
                checks++;
                if (d !== model_mem[widx(a)] || c !== acc + LAT) begin
                    errors++;
                    $display("FAIL rand_read addr %h: got %h @%0d, required %h @%0d", a, d, c,
                             model_mem[widx(a)], acc + LAT);
                end
            end
        end
        checks++;
        if (err_proto !== 1'b0) begin
            errors++;
            $display("FAIL rand_no_err: err_proto=%b, required 0", err_proto);
        end
    endtask

    task automatic test_reset_midburst();
        int acc0, n, t;
        burst3(acc0);
        t = 0;
        while (cyc < acc0 + LAT + 1 && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (ddr4_app_rd_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL midburst_valid: got %b, required 1", ddr4_app_rd_data_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ddr4_app_rd_data_valid, ddr4_app_rd_data_end} !== 2'b00) begin
            errors++;
            $display("FAIL midburst_drop: valid/end=%b, required 00",
                     {ddr4_app_rd_data_valid, ddr4_app_rd_data_end});
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rd_q.size() !== 1) begin
            errors++;
            $display("FAIL midburst_count: got %0d beats, required 1", rd_q.size());
        end
        rd_q.delete(); rd_cyc_q.delete(); rd_end_q.delete();
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        reset = 1'b0;
        wait_calib(n);
        checks++;
        if (n !== CAL) begin
            errors++;
            $display("FAIL recalib: got %0d cycles, required %0d", n, CAL);
        end
    endtask

    task automatic test_proto();
        logic [511:0] g0, g1, d;
        int           acc, c, n, t;
        bit           e;
        g0 = rand512();
        g1 = rand512();
        send_write(28'h18, g0, 64'h0);
        t = 0;
        while (ddr4_app_rdy !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        ddr4_app_en   = 1'b1;
        ddr4_app_cmd  = 3'b010;
        ddr4_app_addr = 28'h18;
        @(posedge clk); #1;
        ddr4_app_en = 1'b0;
        checks++;
        if (err_proto !== 1'b1 || ddr4_app_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bad_cmd: err=%b rdy=%b, required err=1 rdy=1", err_proto,
                     ddr4_app_rdy);
        end
        ddr4_app_wdf_wren = 1'b1;
        ddr4_app_wdf_end  = 1'b0;
        ddr4_app_wdf_data = rand512();
        ddr4_app_wdf_mask = '0;
        @(posedge clk); #1;
        ddr4_app_wdf_wren = 1'b0;
        send_write(28'h20, g1, 64'h0);
        send_cmd(3'b001, 28'h20, acc);
        get_read(d, c, e);
        checks++;
        if (d !== g1) begin
            errors++;
            $display("FAIL bad_beat_dropped: got %h, required %h", d, g1);
        end
        send_cmd(3'b001, 28'h18, acc);
        get_read(d, c, e);
        checks++;
        if (d !== g0) begin
            errors++;
            $display("FAIL bad_cmd_mem: got %h, required %h", d, g0);
        end
        checks++;
        if (err_proto !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b, required 1", err_proto);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (err_proto !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %b, required 0", err_proto);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ddr4_app_en   = 1'b1;
        ddr4_app_cmd  = 3'b001;
        ddr4_app_addr = 28'h0;
        @(posedge clk); #1;
        ddr4_app_en = 1'b0;
        checks++;
        if (err_proto !== 1'b1) begin
            errors++;
            $display("FAIL en_before_calib: err=%b, required 1", err_proto);
        end
        wait_calib(n);
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if (rd_q.size() !== 0) begin
            errors++;
            $display("FAIL early_cmd_ignored: got %0d beats, required 0", rd_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_known[i] = 1'b0;
            model_mem[i]   = '0;
        end
        test_reset();
        test_write_read();
        test_mask();
        test_early_data();
        test_back_to_back();
        test_random();
        test_reset_midburst();
        test_proto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
